// File: rtl/ps2_key_scheduler.sv
// ps2_key_scheduler: filters the raw PS/2 scancode stream, queues make codes in a small
// circular FIFO and hands them one at a time to the Morse encoder. Each hand-off waits for
// the encoder to go idle and for a programmable inter-character gap to elapse.
module ps2_key_scheduler #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GAP_CYCLES = 16,
    parameter logic [7:0]  FLUSH_CODE = 8'h76
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             ps2_received_data,
    input  logic                   ps2_received_data_strb,
    input  logic                   enc_busy,
    output logic [7:0]             enc_data,
    output logic                   enc_data_strb,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    // A zero gap still needs one bit of counter to hold the value 0.
    localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [GapW-1:0] GapInit  = GapW'(GAP_CYCLES);

    localparam logic [7:0] CodeBreak   = 8'hF0;
    localparam logic [7:0] CodeExt     = 8'hE0;
    localparam logic [7:0] CodeError   = 8'h00;
    localparam logic [7:0] CodeBat     = 8'hAA;
    localparam logic [7:0] CodeOverrun = 8'hFF;

    typedef enum logic [1:0] {
        FMake,
        FBrk,
        FExt,
        FExtBrk
    } filt_state_e;

    typedef enum logic [2:0] {
        DIdle,
        DIssue,
        DBlank,
        DWait,
        DGap
    } disp_state_e;

    filt_state_e filt_q, filt_d;
    disp_state_e disp_q, disp_d;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;

    logic [7:0]      enc_data_q, enc_data_d;
    logic            enc_strb_q, enc_strb_d;
    logic            blank_q, blank_d;
    logic [GapW-1:0] gap_q, gap_d;

    logic enq_req;
    logic flush;
    logic wr_en;
    logic deq;

    // Scancode filter: decide per received byte whether it is a make code, a flush or noise.
    always_comb begin
        filt_d  = filt_q;
        enq_req = 1'b0;
        flush   = 1'b0;
        if (ps2_received_data_strb) begin
            unique case (filt_q)
                FMake: begin
                    if (ps2_received_data == CodeBreak) begin
                        filt_d = FBrk;
                    end else if (ps2_received_data == CodeExt) begin
                        filt_d = FExt;
                    end else if (ps2_received_data == FLUSH_CODE) begin
                        flush = 1'b1;
                    end else if (ps2_received_data != CodeError &&
                                 ps2_received_data != CodeBat &&
                                 ps2_received_data != CodeOverrun) begin
                        enq_req = 1'b1;
                    end
                end
                FBrk: begin
                    filt_d = FMake;
                end
                FExt: begin
                    // E0 F0 xx is an extended break: one more byte must be swallowed.
                    filt_d = (ps2_received_data == CodeBreak) ? FExtBrk : FMake;
                end
                FExtBrk: begin
                    filt_d = FMake;
                end
                default: begin
                    filt_d = FMake;
                end
            endcase
        end
    end

    // Dispatch sequencer: issue the head entry, ride out the strobe-to-busy latency, then pace.
    always_comb begin
        disp_d     = disp_q;
        blank_d    = blank_q;
        gap_d      = gap_q;
        enc_data_d = enc_data_q;
        enc_strb_d = 1'b0;
        deq        = 1'b0;
        unique case (disp_q)
            DIdle: begin
                if (count_q != '0 && !enc_busy) begin
                    disp_d = DIssue;
                end
            end
            DIssue: begin
                // A flush between the idle decision and now leaves nothing to send.
                if (count_q != '0) begin
                    deq        = 1'b1;
                    enc_data_d = mem_q[rd_ptr_q];
                    enc_strb_d = 1'b1;
                    blank_d    = 1'b0;
                    disp_d     = DBlank;
                end else begin
                    disp_d = DIdle;
                end
            end
            DBlank: begin
                // Two cycles during which enc_busy may not yet reflect the new character.
                blank_d = ~blank_q;
                if (blank_q) begin
                    disp_d = DWait;
                end
            end
            DWait: begin
                if (!enc_busy) begin
                    gap_d  = GapInit;
                    disp_d = DGap;
                end
            end
            DGap: begin
                if (gap_q == '0) begin
                    disp_d = DIdle;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            default: begin
                disp_d = DIdle;
            end
        endcase
    end

    // FIFO bookkeeping: a full FIFO still accepts a byte when the head leaves in the same cycle.
    always_comb begin
        wr_en      = enq_req && ((count_q != DepthCnt) || deq);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (wr_en && !deq) begin
                count_d = count_q + CntW'(1);
            end else if (!wr_en && deq) begin
                count_d = count_q - CntW'(1);
            end
            if (enq_req && !wr_en) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Storage array; contents need no reset because the count says what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= ps2_received_data;
        end
    end

    // State registers for filter, FIFO pointers and dispatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= FMake;
            disp_q     <= DIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            enc_data_q <= '0;
            enc_strb_q <= 1'b0;
            blank_q    <= 1'b0;
            gap_q      <= '0;
        end else begin
            filt_q     <= filt_d;
            disp_q     <= disp_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            enc_data_q <= enc_data_d;
            enc_strb_q <= enc_strb_d;
            blank_q    <= blank_d;
            gap_q      <= gap_d;
        end
    end

    assign enc_data      = enc_data_q;
    assign enc_data_strb = enc_strb_q;
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_ps2_key_scheduler.sv
// Bench for ps2_key_scheduler: directed scenarios plus a random byte stream, all checked
// against a queue-based model of the filter/FIFO and a reactive encoder model.
module tb_ps2_key_scheduler;

    localparam int unsigned DEPTH      = 8;
    localparam int unsigned GAP        = 16;
    localparam logic [7:0]  FLUSH_CODE = 8'h76;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_strb = 1'b0;
    logic       hold_busy = 1'b0;
    logic       auto_busy = 1'b0;
    logic       enc_busy;
    logic [7:0] enc_data;
    logic       enc_data_strb;
    logic [3:0] fifo_count;
    logic       overflow;

    assign enc_busy = hold_busy | auto_busy;

    ps2_key_scheduler #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP),
        .FLUSH_CODE (FLUSH_CODE)
    ) u_dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ps2_received_data      (ps2_data),
        .ps2_received_data_strb (ps2_strb),
        .enc_busy               (enc_busy),
        .enc_data               (enc_data),
        .enc_data_strb          (enc_data_strb),
        .fifo_count             (fifo_count),
        .overflow               (overflow)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    logic [7:0]  exp_q[$];
    bit          m_ovf = 1'b0;
    bit          skip_next = 1'b0;
    bit          ext_next = 1'b0;
    bit          enq_pend = 1'b0;
    bit          flush_pend = 1'b0;
    logic [7:0]  enq_byte = 8'h00;
    int unsigned want;
    int unsigned n_strb = 0;
    int unsigned last_strb_cyc = 0;
    int unsigned fall_cyc = 0;
    bit          fall_valid = 1'b0;
    bit          armed = 1'b0;
    bit          prev_busy = 1'b0;
    int unsigned peak = 0;

    // Encoder model config
    int unsigned busy_len = 4;
    bit          busy_rand = 1'b0;

    // Filter rules: F0 kills the next byte, E0 kills the next byte (and one more if it is F0).
    task automatic model_byte(input logic [7:0] b);
        if (skip_next) begin
            skip_next = 1'b0;
        end else if (ext_next) begin
            ext_next  = 1'b0;
            skip_next = (b == 8'hF0);
        end else if (b == 8'hF0) begin
            skip_next = 1'b1;
        end else if (b == 8'hE0) begin
            ext_next = 1'b1;
        end else if (b == FLUSH_CODE) begin
            flush_pend = 1'b1;
        end else if (b != 8'h00 && b != 8'hAA && b != 8'hFF) begin
            enq_pend = 1'b1;
            enq_byte = b;
        end
    endtask

    // Monitor/scoreboard on the falling edge: apply the effects of the last rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_ovf      = 1'b0;
            skip_next  = 1'b0;
            ext_next   = 1'b0;
            enq_pend   = 1'b0;
            flush_pend = 1'b0;
            armed      = 1'b0;
            fall_valid = 1'b0;
            prev_busy  = enc_busy;
        end else begin
            if (enc_data_strb) begin
                if (exp_q.size() > 0) want = 32'(exp_q.pop_front());
                else want = 32'h100;
                chk("enc_data", 32'(enc_data), want);
                n_strb++;
                last_strb_cyc = cyc;
                if (fall_valid) chk("gap_after_busy", 32'((cyc - fall_cyc) >= GAP + 1), 1);
                fall_valid = 1'b0;
                armed      = 1'b1;
            end
            if (prev_busy && !enc_busy && armed) begin
                fall_cyc   = cyc;
                fall_valid = 1'b1;
                armed      = 1'b0;
            end
            prev_busy = enc_busy;
            if (flush_pend) begin
                exp_q.delete();
                m_ovf = 1'b0;
            end else if (enq_pend) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(enq_byte);
                else m_ovf = 1'b1;
            end
            enq_pend   = 1'b0;
            flush_pend = 1'b0;
            chk("fifo_count", 32'(fifo_count), exp_q.size());
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (32'(fifo_count) > peak) peak = 32'(fifo_count);
            if (ps2_strb) model_byte(ps2_data);
        end
    end

    // Encoder model: goes busy the cycle after each strobe for busy_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && enc_data_strb) begin
                @(posedge clk);
                #1 auto_busy = 1'b1;
                repeat (busy_rand ? $urandom_range(1, 30) : busy_len) @(posedge clk);
                #1 auto_busy = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        ps2_data = b;
        ps2_strb = 1'b1;
        @(posedge clk);
        #1;
        ps2_strb = 1'b0;
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int unsigned max_cyc);
        int unsigned i = 0;
        while ((exp_q.size() != 0 || fifo_count != 0) && i < max_cyc) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("drain_done", exp_q.size() + 32'(fifo_count), 0);
    endtask

    int unsigned base;
    int unsigned t0;
    int unsigned k;
    logic [7:0]  b;
    logic [7:0]  codes9 [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enc_data", 32'(enc_data), 0);
        chk("rst_enc_strb", 32'(enc_data_strb), 0);
        chk("rst_fifo_count", 32'(fifo_count), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        wait_cycles(2);

        // 1C, F0, 1C: single dispatch, fixed latency
        base = n_strb;
        send(8'h1C);
        t0 = cyc - 1;
        send(8'hF0);
        send(8'h1C);
        wait_drain(200);
        wait_cycles(40);
        chk("t1_strobes", n_strb - base, 1);
        chk("t1_latency", last_strb_cyc - t0, 3);
        chk("t1_count", 32'(fifo_count), 0);

        // Extended make and extended break are dropped
        base = n_strb;
        peak = 0;
        send(8'hE0);
        send(8'h75);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        send(8'h32);
        wait_drain(200);
        wait_cycles(40);
        chk("t2_strobes", n_strb - base, 1);
        chk("t2_peak", peak, 1);

        // Overflow with encoder held busy
        base = n_strb;
        hold_busy = 1'b1;
        for (int i = 0; i < 9; i++) send(codes9[i]);
        wait_cycles(2);
        chk("t3_count_full", 32'(fifo_count), DEPTH);
        chk("t3_overflow", 32'(overflow), 1);
        hold_busy = 1'b0;
        wait_drain(1500);
        wait_cycles(40);
        chk("t3_strobes", n_strb - base, 8);
        chk("t3_overflow_sticky", 32'(overflow), 1);

        // Long busy per character, gap enforced by monitor
        base = n_strb;
        busy_len = 50;
        hold_busy = 1'b1;
        send(8'h1C);
        send(8'h32);
        send(8'h21);
        hold_busy = 1'b0;
        wait_drain(1000);
        wait_cycles(90);
        chk("t4_strobes", n_strb - base, 3);
        busy_len = 10;

        // ESC flush
        base = n_strb;
        hold_busy = 1'b1;
        send(8'h1C);
        send(8'h32);
        send(FLUSH_CODE);
        chk("t5_count", 32'(fifo_count), 0);
        chk("t5_overflow", 32'(overflow), 0);
        hold_busy = 1'b0;
        wait_cycles(60);
        chk("t5_strobes", n_strb - base, 0);

        // Asynchronous reset in the middle of the gap
        base = n_strb;
        hold_busy = 1'b1;
        send(8'h1C);
        send(8'h32);
        send(8'h21);
        send(8'h2A);
        hold_busy = 1'b0;
        k = 0;
        while (n_strb == base && k < 100) begin wait_cycles(1); k++; end
        chk("t6_first_strobe", n_strb - base, 1);
        k = 0;
        while (!fall_valid && k < 100) begin wait_cycles(1); k++; end
        chk("t6_busy_fell", 32'(fall_valid), 1);
        wait_cycles(5);
        chk("t6_queued", 32'(fifo_count), 3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_enc_data", 32'(enc_data), 0);
        chk("t6_rst_enc_strb", 32'(enc_data_strb), 0);
        chk("t6_rst_count", 32'(fifo_count), 0);
        chk("t6_rst_overflow", 32'(overflow), 0);
        wait_cycles(2);
        rst_n = 1'b1;
        base = n_strb;
        wait_cycles(60);
        chk("t6_no_strobe", n_strb - base, 0);

        // Random byte stream against the model
        busy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 31);
            if (k < 3) b = 8'hF0;
            else if (k < 5) b = 8'hE0;
            else if (k == 5) b = FLUSH_CODE;
            else if (k == 6) b = 8'hAA;
            else if (k == 7) b = 8'h00;
            else if (k == 8) b = 8'hFF;
            else b = 8'($urandom_range(1, 8'hDF));
            send(b);
            if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 12));
        end
        wait_drain(4000);
        wait_cycles(80);
        chk("rand_final_count", 32'(fifo_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
